led_pattern_gen: RTL and testbench

//   Parametrised LED pattern engine for board bring-up tops. Divides the fabric

---
 rtl/led_pattern_gen.sv | 251 +++++++++++++++++++++++++
 tb/tb_led_pattern_gen.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
//   LED pattern engine for board bring-up. A free-running divider produces a
//   pattern step every 2**DIV_W clocks; on each step the LEDs advance in one
//   of four modes: down-count, up-count, bounce, or PWM breathe. A new mode is
//   offered over a valid/ready port. It is applied at the first step edge
//   strictly after acceptance, and that step reinitialises the pattern.
//
//   Optional feature macro: LED_PWM_EN
//     defined   -> mode 3 (breathe) with pwm/level/direction registers
//     undefined -> no PWM logic; a requested mode 3 is applied as mode 0
//
// Ports
//   clk        in   1      fabric clock
//   reset      in   1      asynchronous active-low reset (0 = in reset)
//   cfg_valid  in   1      new mode offered
//   cfg_mode   in   2      0=down 1=up 2=bounce 3=breathe
//   cfg_ready  out  1      engine can accept a mode (registered)
//   mode       out  2      currently applied mode (registered)
//   tick       out  1      one-cycle pulse after each step edge (registered)
//   led        out  N_LED  LED drive, active-high (registered)
// -----------------------------------------------------------------------------
module led_pattern_gen #(
    parameter int N_LED = 4,
    parameter int DIV_W = 20,
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [1:0]       cfg_mode,
    output logic             cfg_ready,
    output logic [1:0]       mode,
    output logic             tick,
    output logic [N_LED-1:0] led
);

    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1'b1);
    localparam logic [DIV_W-1:0] DIV_MAX  = {DIV_W{1'b1}};
    localparam logic [N_LED-1:0] LED_ONE  = N_LED'(1'b1);
    localparam logic [N_LED-1:0] LED_ZERO = {N_LED{1'b0}};

    // Elaboration-time sanity check on the parameters.
    if ((N_LED < 32'sd1) || (DIV_W < 32'sd1) || (PWM_W < 32'sd1)) begin : g_param_check
        $error("led_pattern_gen: N_LED, DIV_W and PWM_W must all be >= 1");
    end

    // The configuration handshake: idle (ready) or holding a pending mode.
    typedef enum logic {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_t;

    cfg_state_t       cfg_state_r, cfg_state_nxt_s;
    logic [DIV_W-1:0] div_r;
    logic             tick_r;
    logic [1:0]       pending_r, pending_nxt_s;
    logic [1:0]       mode_r, mode_nxt_s;
    logic [N_LED-1:0] led_r, led_nxt_s;
    logic [N_LED-1:0] pos_r, pos_nxt_s;
    logic             bdir_r, bdir_nxt_s;      // 1 = moving toward MSB
    logic             step_s, accept_s, apply_s;
    logic [1:0]       apply_mode_s;

`ifdef LED_PWM_EN
    localparam logic [PWM_W-1:0] PWM_ONE  = PWM_W'(1'b1);
    localparam logic [PWM_W-1:0] PWM_MAX  = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] PWM_ZERO = {PWM_W{1'b0}};

    logic [PWM_W-1:0] pwm_r;
    logic [PWM_W-1:0] level_r, level_nxt_s;
    logic             ldir_r, ldir_nxt_s;      // 1 = brightening
`endif

    // Step edge, handshake acceptance and mode application strobes.
    always_comb begin
        step_s   = (div_r == DIV_MAX);
        accept_s = cfg_valid && (cfg_state_r == CFG_IDLE);
        // Pending is only visible from the cycle after acceptance, so an offer
        // taken on a step edge naturally waits for the following one.
        apply_s  = step_s && (cfg_state_r == CFG_PEND);
`ifdef LED_PWM_EN
        apply_mode_s = pending_r;
`else
        if (pending_r == 2'd3) begin
            apply_mode_s = 2'd0;
        end else begin
            apply_mode_s = pending_r;
        end
`endif
    end

    // Next-state logic for the configuration handshake.
    always_comb begin
        cfg_state_nxt_s = cfg_state_r;
        pending_nxt_s   = pending_r;
        case (cfg_state_r)
            CFG_IDLE: begin
                if (accept_s) begin
                    cfg_state_nxt_s = CFG_PEND;
                    pending_nxt_s   = cfg_mode;
                end else begin
                    cfg_state_nxt_s = CFG_IDLE;
                end
            end
            CFG_PEND: begin
                if (apply_s) begin
                    cfg_state_nxt_s = CFG_IDLE;
                end else begin
                    cfg_state_nxt_s = CFG_PEND;
                end
            end
            default: begin
                cfg_state_nxt_s = CFG_IDLE;
            end
        endcase
    end

    // Next values of the mode and pattern registers that drive the outputs.
    always_comb begin
        mode_nxt_s = mode_r;
        led_nxt_s  = led_r;
        pos_nxt_s  = pos_r;
        bdir_nxt_s = bdir_r;
`ifdef LED_PWM_EN
        level_nxt_s = level_r;
        ldir_nxt_s  = ldir_r;
`endif
        if (apply_s) begin
            // Mode change step: reinitialise the pattern instead of advancing.
            mode_nxt_s = apply_mode_s;
            led_nxt_s  = LED_ZERO;
            pos_nxt_s  = LED_ONE;
            bdir_nxt_s = 1'b1;
`ifdef LED_PWM_EN
            level_nxt_s = PWM_ZERO;
            ldir_nxt_s  = 1'b1;
`endif
        end else begin
            case (mode_r)
                2'd1: begin
                    if (step_s) begin
                        led_nxt_s = led_r + LED_ONE;
                    end else begin
                        led_nxt_s = led_r;
                    end
                end
                2'd2: begin
                    if (step_s) begin
                        // Show the current position, then move it, so the
                        // first step after a mode change lights bit 0.
                        led_nxt_s = pos_r;
                        if (N_LED == 32'sd1) begin
                            pos_nxt_s = pos_r;
                        end else if (bdir_r) begin
                            pos_nxt_s = pos_r << 1'b1;
                            if (pos_nxt_s[N_LED-1]) begin
                                bdir_nxt_s = 1'b0;
                            end else begin
                                bdir_nxt_s = 1'b1;
                            end
                        end else begin
                            pos_nxt_s = pos_r >> 1'b1;
                            if (pos_nxt_s[0]) begin
                                bdir_nxt_s = 1'b1;
                            end else begin
                                bdir_nxt_s = 1'b0;
                            end
                        end
                    end else begin
                        led_nxt_s = led_r;
                    end
                end
`ifdef LED_PWM_EN
                2'd3: begin
                    led_nxt_s = {N_LED{pwm_r < level_r}};
                    if (step_s) begin
                        // Endpoints are held for one step while direction flips.
                        if (ldir_r) begin
                            if (level_r == PWM_MAX) begin
                                ldir_nxt_s = 1'b0;
                            end else begin
                                level_nxt_s = level_r + PWM_ONE;
                            end
                        end else begin
                            if (level_r == PWM_ZERO) begin
                                ldir_nxt_s = 1'b1;
                            end else begin
                                level_nxt_s = level_r - PWM_ONE;
                            end
                        end
                    end else begin
                        level_nxt_s = level_r;
                    end
                end
`endif
                default: begin
                    if (step_s) begin
                        led_nxt_s = led_r - LED_ONE;
                    end else begin
                        led_nxt_s = led_r;
                    end
                end
            endcase
        end
    end

    // State register: divider, handshake state and all output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_r       <= {DIV_W{1'b0}};
            tick_r      <= 1'b0;
            cfg_state_r <= CFG_IDLE;
            pending_r   <= 2'd0;
            mode_r      <= 2'd0;
            led_r       <= LED_ZERO;
            pos_r       <= LED_ONE;
            bdir_r      <= 1'b1;
        end else begin
            div_r       <= div_r + DIV_ONE;
            tick_r      <= step_s;
            cfg_state_r <= cfg_state_nxt_s;
            pending_r   <= pending_nxt_s;
            mode_r      <= mode_nxt_s;
            led_r       <= led_nxt_s;
            pos_r       <= pos_nxt_s;
            bdir_r      <= bdir_nxt_s;
        end
    end

`ifdef LED_PWM_EN
    // PWM carrier and breathe level registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_r   <= PWM_ZERO;
            level_r <= PWM_ZERO;
            ldir_r  <= 1'b1;
        end else begin
            pwm_r   <= pwm_r + PWM_ONE;
            level_r <= level_nxt_s;
            ldir_r  <= ldir_nxt_s;
        end
    end
`endif

    assign cfg_ready = (cfg_state_r == CFG_IDLE);
    assign mode      = mode_r;
    assign tick      = tick_r;
    assign led       = led_r;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen with N_LED=4, DIV_W=2, PWM_W=3.
// Step edges fall on every 4th clock edge after reset release; edge_cnt
// counts edges since release and samples are taken 1 time unit after each
// rising edge. Expected LED/mode values per step are queued and popped on
// each step edge.
module tb_led_pattern_gen;

    localparam int N_LED = 4;
    localparam int DIV_W = 2;
    localparam int PWM_W = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_mode = 2'd0;
    logic       cfg_ready;
    logic [1:0] mode;
    logic       tick;
    logic [3:0] led;

    typedef struct packed {
        logic [3:0] led;
        logic [1:0] mode;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   edge_cnt = 0;

    led_pattern_gen #(.N_LED(N_LED), .DIV_W(DIV_W), .PWM_W(PWM_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_mode  (cfg_mode),
        .cfg_ready (cfg_ready),
        .mode      (mode),
        .tick      (tick),
        .led       (led)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, edge_cnt=%0d", edge_cnt);
        $fatal(1);
    end

    task automatic tick_clk();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (led !== 4'h0) begin n_miss++; $display("FAIL reset_led: got %h want 0", led); end
        n_vec++; if (mode !== 2'd0) begin n_miss++; $display("FAIL reset_mode: got %0d want 0", mode); end
        n_vec++; if (cfg_ready !== 1'b1) begin n_miss++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
        n_vec++; if (tick !== 1'b0) begin n_miss++; $display("FAIL reset_tick: got %b want 0", tick); end
        reset = 1'b1;
        edge_cnt = 0;
    endtask

    task automatic test_down_count();
        exp_t e;
        logic exp_tick;
        sb_q.push_back('{led: 4'hF, mode: 2'd0});
        sb_q.push_back('{led: 4'hE, mode: 2'd0});
        sb_q.push_back('{led: 4'hD, mode: 2'd0});
        for (int i = 0; i < 12; i++) begin
            tick_clk();
            exp_tick = (edge_cnt % 4 == 0);
            n_vec++;
            if (tick !== exp_tick) begin
                n_miss++; $display("FAIL dc_tick@%0d: got %b want %b", edge_cnt, tick, exp_tick);
            end
            if (exp_tick) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_miss++; $display("FAIL dc_sb_empty@%0d: got nothing want queued entry", edge_cnt);
                end else begin
                    e = sb_q.pop_front();
                    if (led !== e.led || mode !== e.mode) begin
                        n_miss++; $display("FAIL dc_step@%0d: got led=%h mode=%0d want led=%h mode=%0d",
                                           edge_cnt, led, mode, e.led, e.mode);
                    end
                end
            end else if (edge_cnt < 4) begin
                n_vec++;
                if (led !== 4'h0) begin n_miss++; $display("FAIL dc_pre@%0d: got %h want 0", edge_cnt, led); end
            end
        end
    endtask

    task automatic test_bounce();
        exp_t e;
        logic exp_rdy;
        logic [3:0] seq [9];
        seq = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2};
        cfg_valid = 1'b1; cfg_mode = 2'd2;
        tick_clk();                       // edge 13: accepted mid-period
        cfg_valid = 1'b0; cfg_mode = 2'd0;
        n_vec++; if (cfg_ready !== 1'b0) begin n_miss++; $display("FAIL bn_ready_drop: got %b want 0", cfg_ready); end
        for (int i = 0; i < 9; i++) sb_q.push_back('{led: seq[i], mode: 2'd2});
        for (int i = 0; i < 35; i++) begin   // edges 14..48
            tick_clk();
            exp_rdy = (edge_cnt >= 16);
            n_vec++;
            if (cfg_ready !== exp_rdy) begin
                n_miss++; $display("FAIL bn_ready@%0d: got %b want %b", edge_cnt, cfg_ready, exp_rdy);
            end
            if (edge_cnt % 4 == 0) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_miss++; $display("FAIL bn_sb_empty@%0d: got nothing want queued entry", edge_cnt);
                end else begin
                    e = sb_q.pop_front();
                    if (led !== e.led || mode !== e.mode || tick !== 1'b1) begin
                        n_miss++; $display("FAIL bn_step@%0d: got led=%h mode=%0d tick=%b want led=%h mode=%0d tick=1",
                                           edge_cnt, led, mode, tick, e.led, e.mode);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic exp_rdy;
        repeat (3) tick_clk();            // edges 49..51
        cfg_valid = 1'b1; cfg_mode = 2'd1;
        sb_q.push_back('{led: 4'h4, mode: 2'd2});
        sb_q.push_back('{led: 4'h0, mode: 2'd1});
        sb_q.push_back('{led: 4'h1, mode: 2'd1});
        sb_q.push_back('{led: 4'h2, mode: 2'd1});
        tick_clk();                       // edge 52: step edge and acceptance
        cfg_mode = 2'd0;                  // second offer while not ready
        n_vec++;
        e = sb_q.pop_front();
        if (led !== e.led || mode !== e.mode || cfg_ready !== 1'b0) begin
            n_miss++; $display("FAIL b2b_accept@%0d: got led=%h mode=%0d rdy=%b want led=%h mode=%0d rdy=0",
                               edge_cnt, led, mode, cfg_ready, e.led, e.mode);
        end
        for (int i = 0; i < 12; i++) begin   // edges 53..64
            tick_clk();
            if (edge_cnt == 55) cfg_valid = 1'b0;
            exp_rdy = (edge_cnt >= 56);
            n_vec++;
            if (cfg_ready !== exp_rdy) begin
                n_miss++; $display("FAIL b2b_ready@%0d: got %b want %b", edge_cnt, cfg_ready, exp_rdy);
            end
            if (edge_cnt % 4 == 0) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_miss++; $display("FAIL b2b_sb_empty@%0d: got nothing want queued entry", edge_cnt);
                end else begin
                    e = sb_q.pop_front();
                    if (led !== e.led || mode !== e.mode) begin
                        n_miss++; $display("FAIL b2b_step@%0d: got led=%h mode=%0d want led=%h mode=%0d",
                                           edge_cnt, led, mode, e.led, e.mode);
                    end
                end
            end
        end
    endtask

`ifdef LED_PWM_EN
    task automatic test_mode3();
        int lvl;
        int up;
        logic [3:0] exp_led;
        lvl = 0; up = 1;
        cfg_valid = 1'b1; cfg_mode = 2'd3;
        tick_clk();
        cfg_valid = 1'b0;
        for (int i = 0; i < 75; i++) begin   // through 18 steps of breathe
            tick_clk();
            if (edge_cnt == 68) begin
                n_vec++;
                if (led !== 4'h0 || mode !== 2'd3) begin
                    n_miss++; $display("FAIL br_apply: got led=%h mode=%0d want led=0 mode=3", led, mode);
                end
            end else if (edge_cnt > 68) begin
                exp_led = (((edge_cnt - 1) % 8) < lvl) ? 4'hF : 4'h0;
                n_vec++;
                if (led !== exp_led) begin
                    n_miss++; $display("FAIL br_led@%0d: got %h want %h (level %0d)", edge_cnt, led, exp_led, lvl);
                end
                if (edge_cnt % 4 == 0) begin
                    if (up == 1) begin
                        if (lvl == 7) up = 0; else lvl++;
                    end else begin
                        if (lvl == 0) up = 1; else lvl--;
                    end
                end
            end
        end
    endtask
`else
    task automatic test_mode3();
        exp_t e;
        cfg_valid = 1'b1; cfg_mode = 2'd3;
        tick_clk();                       // edge 65 accepted
        cfg_valid = 1'b0; cfg_mode = 2'd0;
        sb_q.push_back('{led: 4'h0, mode: 2'd0});
        sb_q.push_back('{led: 4'hF, mode: 2'd0});
        sb_q.push_back('{led: 4'hE, mode: 2'd0});
        for (int i = 0; i < 11; i++) begin   // edges 66..76
            tick_clk();
            if (edge_cnt % 4 == 0) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_miss++; $display("FAIL m3_sb_empty@%0d: got nothing want queued entry", edge_cnt);
                end else begin
                    e = sb_q.pop_front();
                    if (led !== e.led || mode !== e.mode) begin
                        n_miss++; $display("FAIL m3_fallback@%0d: got led=%h mode=%0d want led=%h mode=%0d",
                                           edge_cnt, led, mode, e.led, e.mode);
                    end
                end
            end
        end
        n_vec++; if (cfg_ready !== 1'b1) begin n_miss++; $display("FAIL m3_ready: got %b want 1", cfg_ready); end
    endtask
`endif

    task automatic test_reset_mid();
        exp_t e;
        logic exp_tick;
        cfg_valid = 1'b1; cfg_mode = 2'd2;
        tick_clk();                       // base+1 accepted
        cfg_valid = 1'b0;
        repeat (8) tick_clk();            // applied at base+4, led=1 at base+8
        n_vec++;
        if (led !== 4'h1 || mode !== 2'd2) begin
            n_miss++; $display("FAIL rm_bounce: got led=%h mode=%0d want led=1 mode=2", led, mode);
        end
        cfg_valid = 1'b1; cfg_mode = 2'd1;
        tick_clk();                       // pending mode 1
        cfg_valid = 1'b0; cfg_mode = 2'd0;
        n_vec++; if (cfg_ready !== 1'b0) begin n_miss++; $display("FAIL rm_pending: got rdy=%b want 0", cfg_ready); end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (led !== 4'h0 || mode !== 2'd0 || cfg_ready !== 1'b1 || tick !== 1'b0) begin
            n_miss++; $display("FAIL rm_async: got led=%h mode=%0d rdy=%b tick=%b want led=0 mode=0 rdy=1 tick=0",
                               led, mode, cfg_ready, tick);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        edge_cnt = 0;
        sb_q.push_back('{led: 4'hF, mode: 2'd0});
        sb_q.push_back('{led: 4'hE, mode: 2'd0});
        for (int i = 0; i < 8; i++) begin
            tick_clk();
            exp_tick = (edge_cnt % 4 == 0);
            n_vec++;
            if (tick !== exp_tick) begin
                n_miss++; $display("FAIL rm_tick@%0d: got %b want %b", edge_cnt, tick, exp_tick);
            end
            if (exp_tick) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_miss++; $display("FAIL rm_sb_empty@%0d: got nothing want queued entry", edge_cnt);
                end else begin
                    e = sb_q.pop_front();
                    if (led !== e.led || mode !== e.mode) begin
                        n_miss++; $display("FAIL rm_restart@%0d: got led=%h mode=%0d want led=%h mode=%0d",
                                           edge_cnt, led, mode, e.led, e.mode);
                    end
                end
            end else if (edge_cnt < 4) begin
                n_vec++;
                if (led !== 4'h0) begin n_miss++; $display("FAIL rm_pre@%0d: got %h want 0", edge_cnt, led); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_down_count();
        test_bounce();
        test_back_to_back();
        test_mode3();
        test_reset_mid();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_miss++; $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
